motor_cmd_sequencer: RTL

Sits between the joystick mode decoder and the dual H-bridge PWM motor block. Arbitrates drive commands from three sources: joystick, an autonomous requester and an emergency stop. Converts the winning command into per-side direction and duty targets. Sequences each side through soft-start/soft-stop ramps and a dead-time interval on direction reversal, so the bridge never flips polarity under load.

---
 rtl/motor_cmd_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: arbitrates drive sources and sequences each bridge side through ramps and dead time
module motor_cmd_sequencer #(
  parameter int RAMP_DIV   = 100000,
  parameter int STEP       = 8,
  parameter int FULL_DUTY  = 255,
  parameter int TURN_DUTY  = 160,
  parameter int DEAD_TICKS = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] joy_mode,
  input  logic       auto_en,
  input  logic [3:0] auto_mode,
  input  logic       estop,
  output logic [1:0] l_IN,
  output logic [1:0] r_IN,
  output logic [7:0] l_duty,
  output logic [7:0] r_duty,
  output logic [1:0] src,
  output logic       busy
);
  localparam int RW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam int DW = $clog2(DEAD_TICKS + 1);
  typedef enum logic [1:0] {RUN, DECEL, DEAD} state_t;
  logic [RW-1:0] ramp_cnt;
  logic          tick;
  logic [3:0]    cmd;
  logic [7:0]    tgt_duty;
  logic [1:0]    side_busy;
  assign tick = ramp_cnt == RW'(RAMP_DIV - 1);
  assign cmd = joy_mode != 4'd0 ? joy_mode : auto_en ? auto_mode : 4'd0;
  assign tgt_duty = (cmd == 4'd1 || cmd == 4'd2) ? 8'(FULL_DUTY) :
                    (cmd == 4'd3 || cmd == 4'd4) ? 8'(TURN_DUTY) : 8'd0;
  always_ff @(posedge clk) begin
    ramp_cnt <= (rst || tick) ? '0 : ramp_cnt + 1'b1;
    src      <= rst ? 2'd0 : estop ? 2'd3 : joy_mode != 4'd0 ? 2'd1 : auto_en ? 2'd2 : 2'd0;
    busy     <= rst ? 1'b0 : |side_busy;
  end
  for (genvar s = 0; s < 2; s++) begin : g_side
    state_t        st;
    logic [1:0]    cur_dir, in_q, tgt_dir;
    logic [7:0]    duty, ramp, dec;
    logic [8:0]    up;
    logic [DW-1:0] cnt;
    // side 0 is left: a LEFT pivot reverses the left wheel, a RIGHT pivot the right one
    assign tgt_dir = cmd == 4'd1 ? 2'b10 : cmd == 4'd2 ? 2'b01 :
                     cmd == 4'd3 ? (s == 0 ? 2'b01 : 2'b10) :
                     cmd == 4'd4 ? (s == 0 ? 2'b10 : 2'b01) : cur_dir;
    assign up   = {1'b0, duty} + 9'(STEP);
    assign ramp = duty < tgt_duty ? (up > {1'b0, tgt_duty} ? tgt_duty : up[7:0]) :
                  duty > tgt_duty ? (duty - tgt_duty > 8'(STEP) ? duty - 8'(STEP) : tgt_duty) : duty;
    assign dec  = duty > 8'(STEP) ? duty - 8'(STEP) : 8'd0;
    assign side_busy[s] = st != RUN || duty != tgt_duty || tgt_dir != cur_dir;
    always_ff @(posedge clk) begin
      if (rst) begin
        st      <= RUN;
        cur_dir <= 2'b00;
        in_q    <= 2'b00;
        duty    <= 8'd0;
        cnt     <= '0;
      end else if (estop) begin
        st   <= DEAD;
        in_q <= 2'b00;
        duty <= 8'd0;
        cnt  <= DW'(DEAD_TICKS);
      end else begin
        case (st)
          RUN:
            if (tgt_dir == cur_dir) begin
              if (tick) duty <= ramp;
            end else if (duty != 8'd0) st <= DECEL;
            else begin
              st   <= DEAD;
              in_q <= 2'b00;
              cnt  <= DW'(DEAD_TICKS);
            end
          DECEL:
            if (tgt_dir == cur_dir) st <= RUN;
            else if (duty == 8'd0) begin
              st   <= DEAD;
              in_q <= 2'b00;
              cnt  <= DW'(DEAD_TICKS);
            end else if (tick) duty <= dec;
          default:
            // coast lasts exactly DEAD_TICKS cycles before the new polarity is applied
            if (cnt < DW'(2)) begin
              st      <= RUN;
              cur_dir <= tgt_dir;
              in_q    <= tgt_dir;
            end else cnt <= cnt - 1'b1;
        endcase
      end
    end
  end
  assign l_IN   = g_side[0].in_q;
  assign r_IN   = g_side[1].in_q;
  assign l_duty = g_side[0].duty;
  assign r_duty = g_side[1].duty;
endmodule
